// File: rtl/sprite_pixel_reader.sv
// rtl/sprite_pixel_reader.sv - raster-to-ROM sprite pixel fetch with hit/opaque flags and opaque pixel counter
module sprite_pixel_reader #(
    parameter int          SPR_W     = 32,
    parameter int          SPR_H     = 24,
    parameter int          ADDR_W    = 11,
    parameter int          SCALE_SH  = 0,
    parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              sprite_en,
    input  logic [9:0]        SprX,
    input  logic [9:0]        SprY,
    input  logic              pix_valid,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              out_valid,
    output logic              out_hit,
    output logic              out_opaque,
    output logic [23:0]       out_rgb,
    output logic [15:0]       opaque_count
);
    localparam logic [10:0] BOX_W = 11'(SPR_W << SCALE_SH);
    localparam logic [10:0] BOX_H = 11'(SPR_H << SCALE_SH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state_q, state_d;
    logic [9:0]  pos_x, pos_y;
    logic        en_l;
    logic [9:0]  eff_x, eff_y;
    logic        eff_en;
    logic [10:0] dx, dy;
    logic [9:0]  col, row;
    logic        hit;
    logic        s1_valid, s1_hit, s2_valid, s2_hit;
    logic        opaque_next;
    logic [15:0] cnt, cnt_inc;

    always_comb begin
        state_d = state_q;
        if (frame_start) state_d = ACTIVE;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pos_x <= 10'd0;
            pos_y <= 10'd0;
            en_l  <= 1'b0;
        end else if (frame_start) begin
            pos_x <= SprX;
            pos_y <= SprY;
            en_l  <= sprite_en;
        end
    end

    // A pixel arriving with frame_start already sees the newly sampled position.
    assign eff_x  = frame_start ? SprX : pos_x;
    assign eff_y  = frame_start ? SprY : pos_y;
    assign eff_en = frame_start ? sprite_en : ((state_q == ACTIVE) && en_l);

    assign dx  = {1'b0, DrawX} - {1'b0, eff_x};
    assign dy  = {1'b0, DrawY} - {1'b0, eff_y};
    assign hit = pix_valid && eff_en && !dx[10] && (dx < BOX_W) && !dy[10] && (dy < BOX_H);
    assign col = dx[9:0] >> SCALE_SH;
    assign row = dy[9:0] >> SCALE_SH;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr <= '0;
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s2_valid <= 1'b0;
            s2_hit   <= 1'b0;
        end else begin
            if (hit) rom_addr <= ADDR_W'(21'(row) * 21'(SPR_W) + 21'(col));
            s1_valid <= pix_valid;
            s1_hit   <= hit;
            s2_valid <= s1_valid;
            s2_hit   <= s1_hit;
        end
    end

    assign opaque_next = s2_valid && s2_hit && (rom_data != KEY_COLOR);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid  <= 1'b0;
            out_hit    <= 1'b0;
            out_opaque <= 1'b0;
            out_rgb    <= 24'h000000;
        end else begin
            out_valid  <= s2_valid;
            out_hit    <= s2_valid && s2_hit;
            out_opaque <= opaque_next;
            out_rgb    <= opaque_next ? rom_data : 24'h000000;
        end
    end

    // cnt_inc already folds in the opaque pixel leaving the pipe this cycle.
    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + {15'd0, out_opaque};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt          <= 16'd0;
            opaque_count <= 16'd0;
        end else if (frame_start) begin
            opaque_count <= cnt_inc;
            cnt          <= 16'd0;
        end else begin
            cnt <= cnt_inc;
        end
    end
endmodule

// File: tb/tb_sprite_pixel_reader.sv
// tb/tb_sprite_pixel_reader.sv - randomized self-checking bench for sprite_pixel_reader at scale 1x and 2x
module tb_sprite_pixel_reader;
    localparam int          W   = 32;
    localparam int          H   = 24;
    localparam int          AW  = 11;
    localparam logic [23:0] KEY = 24'hFF00FF;

    typedef struct packed {
        logic        v;
        logic        h;
        logic        o;
        logic [23:0] rgb;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          frame_start = 1'b0;
    logic          sprite_en = 1'b0;
    logic [9:0]    SprX = '0, SprY = '0, DrawX = '0, DrawY = '0;
    logic          pix_valid = 1'b0;

    logic [AW-1:0] rom_addr0, rom_addr1;
    logic [23:0]   rom_data0, rom_data1;
    logic          out_valid0, out_hit0, out_opaque0;
    logic          out_valid1, out_hit1, out_opaque1;
    logic [23:0]   out_rgb0, out_rgb1;
    logic [15:0]   opaque_count0, opaque_count1;

    logic [23:0]   rom [0:2047];

    int   errs = 0;
    int   checks = 0;
    bit   m_active, m_en;
    int   m_sx, m_sy;
    int   m_addr0, m_addr1, m_cnt0, m_cnt1, m_pub0, m_pub1;
    exp_t q0[$];
    exp_t q1[$];

    sprite_pixel_reader #(.SPR_W(W), .SPR_H(H), .ADDR_W(AW), .SCALE_SH(0), .KEY_COLOR(KEY)) dut0 (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .sprite_en(sprite_en),
        .SprX(SprX), .SprY(SprY), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .rom_addr(rom_addr0), .rom_data(rom_data0), .out_valid(out_valid0), .out_hit(out_hit0),
        .out_opaque(out_opaque0), .out_rgb(out_rgb0), .opaque_count(opaque_count0));

    sprite_pixel_reader #(.SPR_W(W), .SPR_H(H), .ADDR_W(AW), .SCALE_SH(1), .KEY_COLOR(KEY)) dut1 (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .sprite_en(sprite_en),
        .SprX(SprX), .SprY(SprY), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .rom_addr(rom_addr1), .rom_data(rom_data1), .out_valid(out_valid1), .out_hit(out_hit1),
        .out_opaque(out_opaque1), .out_rgb(out_rgb1), .opaque_count(opaque_count1));

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        rom_data0 <= rom[rom_addr0];
        rom_data1 <= rom[rom_addr1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_pix(input int sh, input bit pv, input int x, input int y,
                                       output bit hit, output int addr);
        exp_t e;
        int   dx, dy;
        dx   = x - m_sx;
        dy   = y - m_sy;
        hit  = pv && m_active && m_en && dx >= 0 && dx < (W << sh) && dy >= 0 && dy < (H << sh);
        addr = 0;
        if (hit) addr = ((dy >> sh) * W + (dx >> sh)) % (1 << AW);
        e.v   = pv;
        e.h   = hit;
        e.o   = hit && (rom[addr] != KEY);
        e.rgb = e.o ? rom[addr] : 24'h000000;
        return e;
    endfunction

    task automatic check_dut(input string n, input exp_t e, input int ea, input int ep,
                             input logic [AW-1:0] addr, input logic v, input logic h, input logic o,
                             input logic [23:0] rgb, input logic [15:0] cnt);
        check({n, ".rom_addr"},     32'(addr), 32'(ea));
        check({n, ".out_valid"},    32'(v),    32'(e.v));
        check({n, ".out_hit"},      32'(h),    32'(e.h));
        check({n, ".out_opaque"},   32'(o),    32'(e.o));
        check({n, ".out_rgb"},      32'(rgb),  32'(e.rgb));
        check({n, ".opaque_count"}, 32'(cnt),  32'(ep));
    endtask

    task automatic step(input bit fs, input bit en, input int sx, input int sy,
                        input bit pv, input int x, input int y);
        exp_t e;
        bit   h;
        int   a;
        frame_start = fs;
        sprite_en   = en;
        SprX        = 10'(sx);
        SprY        = 10'(sy);
        pix_valid   = pv;
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        if (fs) begin
            m_active = 1'b1;
            m_en     = en;
            m_sx     = sx;
            m_sy     = sy;
            m_pub0   = m_cnt0;
            m_pub1   = m_cnt1;
            m_cnt0   = 0;
            m_cnt1   = 0;
        end
        e = model_pix(0, pv, x, y, h, a);
        if (h) m_addr0 = a;
        q0.push_back(e);
        e = model_pix(1, pv, x, y, h, a);
        if (h) m_addr1 = a;
        q1.push_back(e);
        @(posedge Clk);
        #1;
        e = q0.pop_front();
        check_dut("s0", e, m_addr0, m_pub0, rom_addr0, out_valid0, out_hit0, out_opaque0, out_rgb0, opaque_count0);
        if (e.o && m_cnt0 < 65535) m_cnt0++;
        e = q1.pop_front();
        check_dut("s1", e, m_addr1, m_pub1, rom_addr1, out_valid1, out_hit1, out_opaque1, out_rgb1, opaque_count1);
        if (e.o && m_cnt1 < 65535) m_cnt1++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        #1;
        check("rst.rom_addr0", 32'(rom_addr0), 0);
        check("rst.rom_addr1", 32'(rom_addr1), 0);
        check("rst.out_valid", 32'({out_valid0, out_valid1}), 0);
        check("rst.out_hit", 32'({out_hit0, out_hit1}), 0);
        check("rst.out_opaque", 32'({out_opaque0, out_opaque1}), 0);
        check("rst.out_rgb0", 32'(out_rgb0), 0);
        check("rst.out_rgb1", 32'(out_rgb1), 0);
        check("rst.opaque_count0", 32'(opaque_count0), 0);
        check("rst.opaque_count1", 32'(opaque_count1), 0);
        repeat (2) @(posedge Clk);
        #1;
        Reset    = 1'b0;
        m_active = 1'b0;
        m_en     = 1'b0;
        m_sx     = 0;
        m_sy     = 0;
        m_addr0  = 0;
        m_addr1  = 0;
        m_cnt0   = 0;
        m_cnt1   = 0;
        m_pub0   = 0;
        m_pub1   = 0;
        q0.delete();
        q1.delete();
        repeat (2) begin
            q0.push_back('0);
            q1.push_back('0);
        end
        check("rel.out_valid", 32'({out_valid0, out_valid1}), 0);
    endtask

    task automatic rand_frame(input int n);
        int  sx, sy, x, y;
        bit  en;
        sx = $urandom_range(0, 620);
        sy = $urandom_range(0, 470);
        en = ($urandom_range(0, 3) != 0);
        step(1, en, sx, sy, $urandom_range(0, 1) == 1, sx, sy);
        for (int i = 0; i < n; i++) begin
            x = sx + int'($urandom_range(0, 80)) - 8;
            y = sy + int'($urandom_range(0, 60)) - 6;
            if (x < 0) x = 0;
            if (y < 0) y = 0;
            // Position inputs wander mid-frame; only the latched values may matter.
            step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 3) != 0, x, y);
        end
    endtask

    initial begin
        int sx, sy;
        #3;
        apply_reset();
        for (int i = 0; i < 2048; i++)
            rom[i] = ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom);

        rom[0] = KEY;
        step(1, 1, 100, 50, 0, 0, 0);
        step(0, 1, 100, 50, 1, 100, 50);
        step(0, 1, 100, 50, 1, 131, 73);
        step(0, 1, 100, 50, 1, 132, 50);
        step(0, 1, 100, 50, 1, 99, 50);
        idle(3);
        rom[0] = 24'h12AB34;
        step(0, 1, 100, 50, 1, 100, 50);
        idle(3);

        step(1, 1, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 1, 1, 1);
        step(0, 1, 0, 0, 1, 63, 47);
        step(0, 1, 0, 0, 1, 64, 0);
        step(0, 1, 0, 0, 1, 31, 23);
        step(0, 1, 0, 0, 1, 32, 0);
        idle(3);

        for (int i = 0; i < 2048; i++) rom[i] = 24'(i) + 24'h000001;
        step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++) step(0, 1, 0, 0, 1, i % 32, i / 32);
        idle(3);
        step(1, 1, 0, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 50; i++) step(0, 1, 0, 0, 1, 200 + i, 100);
        idle(3);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 50; i++) step(0, 1, 0, 0, 1, i % 32, i / 32);
        idle(3);
        step(1, 1, 0, 0, 0, 0, 0);
        idle(3);

        for (int i = 0; i < 2048; i++)
            rom[i] = ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom);
        repeat (20) rand_frame(300);

        step(0, 1, 10, 10, 1, 12, 12);
        apply_reset();
        idle(4);

        sx = $urandom_range(560, 620);
        sy = $urandom_range(10, 400);
        step(1, 1, sx, sy, 0, 0, 0);
        for (int r = 0; r < 40; r++)
            for (int x = 0; x < 640; x++)
                step(0, 1, sx, sy, 1, x, sy - 4 + r);
        step(1, 1, 0, 0, 0, 0, 0);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
